// File: rtl/distributor_pkg.sv
// rtl/distributor_pkg.sv - shared types and raster reference helpers for distributor_stream
// Optional counters in the top are enabled by DISTRIBUTOR_FRAME_COUNT_EN.
package distributor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } dist_state_t;

  localparam int DEF_PIXEL_DATA_WIDTH = 10;
  localparam int DEF_SCREEN_WIDTH     = 640;
  localparam int DEF_SCREEN_HEIGHT    = 480;
  localparam int DEF_NUM_ENGINES      = 12;
  localparam int FRAME_PIXELS         = DEF_SCREEN_WIDTH * DEF_SCREEN_HEIGHT;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } pix_coord_t;

  // Raster position of a linear pixel index; reference only, never in the datapath.
  function automatic pix_coord_t pixel_coord(input int unsigned idx, input int unsigned width);
    pix_coord_t c;
    c.x = idx % width;
    c.y = idx / width;
    return c;
  endfunction

endpackage

// File: rtl/distributor_lane_gen.sv
// rtl/distributor_lane_gen.sv - per-lane coordinate generation from the batch base (x0, y0)
module distributor_lane_gen
  import distributor_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int LANE             = 0
) (
  input  logic [PIXEL_DATA_WIDTH-1:0] x0,
  input  logic [PIXEL_DATA_WIDTH-1:0] y0,
  output logic [PIXEL_DATA_WIDTH-1:0] x,
  output logic [PIXEL_DATA_WIDTH-1:0] y,
  output logic                        lane_valid
);

  localparam int PW = PIXEL_DATA_WIDTH;
  localparam logic [PW:0] W_EXT    = (PW+1)'(SCREEN_WIDTH);
  localparam logic [PW:0] H_EXT    = (PW+1)'(SCREEN_HEIGHT);
  localparam logic [PW:0] LANE_EXT = (PW+1)'(LANE);
  localparam logic [PW:0] ONE_EXT  = (PW+1)'(1);

  logic [PW:0] xs;
  logic [PW:0] xw;
  logic [PW:0] yw;

  // Lane offset never exceeds one line width, so one conditional wrap suffices.
  always_comb begin
    xs = {1'b0, x0} + LANE_EXT;
    if (xs >= W_EXT) begin
      xw = xs - W_EXT;
      yw = {1'b0, y0} + ONE_EXT;
    end else begin
      xw = xs;
      yw = {1'b0, y0};
    end
    lane_valid = (yw < H_EXT);
    x = lane_valid ? PW'(xw) : '0;
    y = lane_valid ? PW'(yw) : '0;
  end

endmodule

// File: rtl/distributor_stream.sv
// rtl/distributor_stream.sv - raster batch distributor for an engine array, valid/ready output
// DISTRIBUTOR_FRAME_COUNT_EN adds frame_count and underflow_cycles outputs.
module distributor_stream
  import distributor_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int NUM_ENGINES      = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        continuous,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [PIXEL_DATA_WIDTH-1:0] x [NUM_ENGINES],
  output logic [PIXEL_DATA_WIDTH-1:0] y [NUM_ENGINES],
  output logic [NUM_ENGINES-1:0]      lane_valid,
  output logic                        batch_last,
  output logic                        busy,
  output logic                        frame_done
`ifdef DISTRIBUTOR_FRAME_COUNT_EN
  ,
  output logic [15:0]                 frame_count,
  output logic [15:0]                 underflow_cycles
`endif
);

  localparam int PW = PIXEL_DATA_WIDTH;
  typedef logic [PW-1:0] coord_t;
  localparam logic [PW:0] W_EXT  = (PW+1)'(SCREEN_WIDTH);
  localparam logic [PW:0] N_EXT  = (PW+1)'(NUM_ENGINES);
  localparam coord_t      X_LAST = coord_t'(SCREEN_WIDTH - 1);
  localparam coord_t      Y_LAST = coord_t'(SCREEN_HEIGHT - 1);

  dist_state_t state_q, state_d;
  coord_t      x0_q, x0_d;
  coord_t      y0_q, y0_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [PW:0] nx;

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_lane
    distributor_lane_gen #(
      .PIXEL_DATA_WIDTH(PIXEL_DATA_WIDTH),
      .SCREEN_WIDTH    (SCREEN_WIDTH),
      .SCREEN_HEIGHT   (SCREEN_HEIGHT),
      .LANE            (g)
    ) u_lane (
      .x0        (x0_q),
      .y0        (y0_q),
      .x         (x[g]),
      .y         (y[g]),
      .lane_valid(lane_valid[g])
    );
  end

  // Last lane invalid means it already ran past the final pixel.
  assign batch_last = !lane_valid[NUM_ENGINES-1] ||
                      (x[NUM_ENGINES-1] == X_LAST && y[NUM_ENGINES-1] == Y_LAST);

  always_comb begin
    nx           = {1'b0, x0_q} + N_EXT;
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          x0_d        = '0;
          y0_d        = '0;
        end
      end
      default: begin
        if (out_ready) begin
          if (batch_last) begin
            x0_d         = '0;
            y0_d         = '0;
            frame_done_d = 1'b1;
            if (!continuous) begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              busy_d      = 1'b0;
            end
          end else if (nx < W_EXT) begin
            x0_d = PW'(nx);
          end else begin
            x0_d = PW'(nx - W_EXT);
            y0_d = y0_q + coord_t'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef DISTRIBUTOR_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] underflow_q, underflow_d;

  // Counter steps alongside the frame_done pulse, so both appear together.
  always_comb begin
    frame_count_d = frame_count_q + (frame_done_d ? 16'd1 : 16'd0);
    underflow_d   = underflow_q;
    if (state_q == IDLE && start) begin
      underflow_d = '0;
    end else if (state_q == ISSUE && !out_ready && underflow_q != 16'hFFFF) begin
      underflow_d = underflow_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
      underflow_q   <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      underflow_q   <= underflow_d;
    end
  end

  assign frame_count      = frame_count_q;
  assign underflow_cycles = underflow_q;
`endif

endmodule

// File: tb/tb_distributor_stream.sv
// tb/tb_distributor_stream.sv - self-checking bench: default 640x480x12 and a 10x2x3 instance
module tb_distributor_stream;
  import distributor_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, cont_a, rdy_a, ov_a, bl_a, busy_a, fd_a;
  logic [9:0] x_a [12];
  logic [9:0] y_a [12];
  logic [11:0] lv_a;
  logic start_b, cont_b, rdy_b, ov_b, bl_b, busy_b, fd_b;
  logic [3:0] x_b [3];
  logic [3:0] y_b [3];
  logic [2:0] lv_b;
`ifdef DISTRIBUTOR_FRAME_COUNT_EN
  logic [15:0] fc_a, uc_a, fc_b, uc_b;
`endif

  distributor_stream u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .continuous(cont_a), .out_ready(rdy_a),
    .out_valid(ov_a), .x(x_a), .y(y_a), .lane_valid(lv_a), .batch_last(bl_a),
    .busy(busy_a), .frame_done(fd_a)
`ifdef DISTRIBUTOR_FRAME_COUNT_EN
    , .frame_count(fc_a), .underflow_cycles(uc_a)
`endif
  );

  distributor_stream #(
    .PIXEL_DATA_WIDTH(4), .SCREEN_WIDTH(10), .SCREEN_HEIGHT(2), .NUM_ENGINES(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .continuous(cont_b), .out_ready(rdy_b),
    .out_valid(ov_b), .x(x_b), .y(y_b), .lane_valid(lv_b), .batch_last(bl_b),
    .busy(busy_b), .frame_done(fd_b)
`ifdef DISTRIBUTOR_FRAME_COUNT_EN
    , .frame_count(fc_b), .underflow_cycles(uc_b)
`endif
  );

  typedef struct packed {
    logic [3:0] x0, x1, x2, y0, y1, y2;
    logic [2:0] lv;
    logic       bl;
  } vec_t;

  vec_t tbl [7];
  int vecs, errs;
  int gx [12];
  int gy [12];
  logic [11:0] glv;
  logic gbl, gov, gfd, gbusy;
  int st, xf;

  function automatic int cw(input int s); return (s != 0) ? 10 : DEF_SCREEN_WIDTH; endfunction
  function automatic int ch(input int s); return (s != 0) ? 2 : DEF_SCREEN_HEIGHT; endfunction
  function automatic int cn(input int s); return (s != 0) ? 3 : DEF_NUM_ENGINES; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic snap(input int s);
    for (int i = 0; i < 12; i++) begin
      gx[i] = 0;
      gy[i] = 0;
    end
    if (s == 0) begin
      for (int i = 0; i < 12; i++) begin
        gx[i] = int'(x_a[i]);
        gy[i] = int'(y_a[i]);
      end
      glv = lv_a; gbl = bl_a; gov = ov_a; gfd = fd_a; gbusy = busy_a;
    end else begin
      for (int i = 0; i < 3; i++) begin
        gx[i] = int'(x_b[i]);
        gy[i] = int'(y_b[i]);
      end
      glv = 12'(lv_b); gbl = bl_b; gov = ov_b; gfd = fd_b; gbusy = busy_b;
    end
  endtask

  task automatic set_ready(input int s, input logic v);
    if (s == 0) rdy_a = v; else rdy_b = v;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start_a = v; else start_b = v;
  endtask

  task automatic do_start(input int s);
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
  endtask

  // Expected batch starting at linear pixel p, derived from raster arithmetic.
  task automatic check_batch(input int s, input int p, input string tag);
    int w = cw(s);
    int h = ch(s);
    int n = cn(s);
    int bad = -1;
    int ex, ey;
    logic ev, eb;
    pix_coord_t e;
    string msg;
    for (int i = 0; i < n; i++) begin
      if (p + i < w * h) begin
        e = pixel_coord(p + i, w);
        ex = int'(e.x); ey = int'(e.y); ev = 1'b1;
      end else begin
        ex = 0; ey = 0; ev = 1'b0;
      end
      if (bad < 0 && (gx[i] != ex || gy[i] != ey || glv[i] !== ev)) begin
        bad = i;
        msg = $sformatf("lane %0d got (%0d,%0d,%0b) expected (%0d,%0d,%0b)",
                        i, gx[i], gy[i], glv[i], ex, ey, ev);
      end
    end
    eb = (p + n - 1 >= w * h - 1);
    if (bad < 0 && gbl !== eb) begin
      bad = n;
      msg = $sformatf("batch_last got %0b expected %0b", gbl, eb);
    end
    vecs++;
    if (bad >= 0) begin
      errs++;
      $display("FAIL %s pixel %0d: %s", tag, p, msg);
    end
  endtask

  task automatic run_frame(input int s, input bit bp, input int poke, output int stalls, output int xfers);
    int p = 0;
    bit done = 0;
    logic r;
    stalls = 0;
    xfers = 0;
    for (int c = 0; c < 40000 && !done; c++) begin
      snap(s);
      chk("out_valid_in_frame", 32'(gov), 1);
      if (c > 0) chk("frame_done_mid", 32'(gfd), 0);
      check_batch(s, p, "batch");
      if (s == 0 && p == 648) begin
        chk("b54_x_lane0", gx[0], 8);
        chk("b54_y_lane0", gy[0], 1);
        chk("b54_x_lane4", gx[4], 12);
        chk("b54_y_lane4", gy[4], 1);
      end
      r = bp ? logic'($urandom_range(0, 99) < 60) : 1'b1;
      set_ready(s, r);
      set_start(s, logic'(c == poke));
      if (!r) stalls++;
      tick();
      if (r) begin
        xfers++;
        if (p + cn(s) >= cw(s) * ch(s)) done = 1;
        else p += cn(s);
      end
    end
    set_start(s, 1'b0);
    if (!done) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    vecs = 0; errs = 0;
    tbl[0] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 3'b111, 1'b0};
    tbl[1] = '{4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0, 3'b111, 1'b0};
    tbl[2] = '{4'd6, 4'd7, 4'd8, 4'd0, 4'd0, 4'd0, 3'b111, 1'b0};
    tbl[3] = '{4'd9, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 3'b111, 1'b0};
    tbl[4] = '{4'd2, 4'd3, 4'd4, 4'd1, 4'd1, 4'd1, 3'b111, 1'b0};
    tbl[5] = '{4'd5, 4'd6, 4'd7, 4'd1, 4'd1, 4'd1, 3'b111, 1'b0};
    tbl[6] = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd1, 4'd0, 3'b011, 1'b1};

    // Reset with start held high: reset must win.
    reset = 1'b1;
    start_a = 1'b1; cont_a = 1'b0; rdy_a = 1'b0;
    start_b = 1'b1; cont_b = 1'b0; rdy_b = 1'b0;
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      snap(s);
      chk("reset_out_valid", 32'(gov), 0);
      chk("reset_busy", 32'(gbusy), 0);
      chk("reset_frame_done", 32'(gfd), 0);
    end
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    tick();
    snap(1);
    chk("idle_out_valid", 32'(gov), 0);
`ifdef DISTRIBUTOR_FRAME_COUNT_EN
    chk("reset_frame_count", 32'(fc_b), 0);
    chk("reset_underflow", 32'(uc_b), 0);
`endif

    // Small raster, table-driven, no backpressure.
    rdy_b = 1'b1;
    do_start(1);
    for (int b = 0; b < 7; b++) begin
      snap(1);
      chk($sformatf("tbl%0d_valid", b), 32'(gov), 1);
      chk($sformatf("tbl%0d_x0", b), gx[0], 32'(tbl[b].x0));
      chk($sformatf("tbl%0d_x1", b), gx[1], 32'(tbl[b].x1));
      chk($sformatf("tbl%0d_x2", b), gx[2], 32'(tbl[b].x2));
      chk($sformatf("tbl%0d_y0", b), gy[0], 32'(tbl[b].y0));
      chk($sformatf("tbl%0d_y1", b), gy[1], 32'(tbl[b].y1));
      chk($sformatf("tbl%0d_y2", b), gy[2], 32'(tbl[b].y2));
      chk($sformatf("tbl%0d_lv", b), 32'(glv[2:0]), 32'(tbl[b].lv));
      chk($sformatf("tbl%0d_last", b), 32'(gbl), 32'(tbl[b].bl));
      tick();
    end
    snap(1);
    chk("tbl_frame_done", 32'(gfd), 1);
    chk("tbl_end_valid", 32'(gov), 0);
    chk("tbl_end_busy", 32'(gbusy), 0);
    tick();
    snap(1);
    chk("tbl_frame_done_once", 32'(gfd), 0);

    // Start pulsed mid-frame must not disturb the sequence.
    do_start(1);
    run_frame(1, 1'b0, 2, st, xf);
    chk("busy_start_xfers", xf, 7);
    snap(1);
    chk("busy_start_done", 32'(gfd), 1);
    chk("busy_start_end_valid", 32'(gov), 0);
`ifdef DISTRIBUTOR_FRAME_COUNT_EN
    chk("frame_count_two", 32'(fc_b), 2);
`endif
    tick();

    // Random backpressure.
    for (int k = 0; k < 3; k++) begin
      do_start(1);
      run_frame(1, 1'b1, -1, st, xf);
      chk("bp_xfers", xf, 7);
      snap(1);
      chk("bp_frame_done", 32'(gfd), 1);
      chk("bp_end_valid", 32'(gov), 0);
`ifdef DISTRIBUTOR_FRAME_COUNT_EN
      chk("bp_underflow", 32'(uc_b), st);
`endif
      tick();
      snap(1);
      chk("bp_done_once", 32'(gfd), 0);
    end

    // Continuous mode, cleared during the second frame.
    cont_b = 1'b1;
    do_start(1);
    run_frame(1, 1'b1, -1, st, xf);
    snap(1);
    chk("cont_frame_done", 32'(gfd), 1);
    chk("cont_valid_held", 32'(gov), 1);
    check_batch(1, 0, "cont_restart");
    cont_b = 1'b0;
    run_frame(1, 1'b1, -1, st, xf);
    snap(1);
    chk("cont_stop_done", 32'(gfd), 1);
    chk("cont_stop_valid", 32'(gov), 0);
    chk("cont_stop_busy", 32'(gbusy), 0);

    // Full default frame, ready always high.
    rdy_a = 1'b1;
    do_start(0);
    run_frame(0, 1'b0, -1, st, xf);
    chk("full_xfers", xf, FRAME_PIXELS / DEF_NUM_ENGINES);
    snap(0);
    chk("full_frame_done", 32'(gfd), 1);
    chk("full_end_valid", 32'(gov), 0);
    tick();
    snap(0);
    chk("full_done_once", 32'(gfd), 0);

    // Reset mid-frame while presenting batch 10.
    do_start(0);
    repeat (10) tick();
    snap(0);
    check_batch(0, 120, "pre_reset");
    reset = 1'b1;
    #1;
    snap(0);
    chk("async_reset_valid", 32'(gov), 0);
    chk("async_reset_busy", 32'(gbusy), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      snap(0);
      chk("post_reset_no_done", 32'(gfd), 0);
      chk("post_reset_idle", 32'(gov), 0);
    end
    do_start(0);
    snap(0);
    chk("restart_valid", 32'(gov), 1);
    chk("restart_busy", 32'(gbusy), 1);
    check_batch(0, 0, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
